// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: types and constants shared by the AES round scheduler.
//   state_t      - controller states
//   NROUNDS_DEF  - default number of round-enable pulses per operation
//   IDXW         - width of the round_idx output
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NROUNDS_DEF = 10;
  localparam int IDXW        = 4;

endpackage

// File: rtl/aes_round_sched_tick_div.sv
// tick_div: programmable power-of-two tick counter.
//   clk50   in   clock
//   reset   in   asynchronous active-high reset
//   clear   in   synchronous clear of the count
//   en      in   count enable
//   div_lat in   divide select; period = 2^div_lat cycles
//   tick    out  high in the cycle the count sits at its terminal value
//                (2^div_lat - 1) while enabled; the count wraps at the
//                following edge
module tick_div #(
  parameter int DIVW = 3
) (
  input  logic            clk50,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic [DIVW-1:0] div_lat,
  output logic            tick
);

  localparam int CW = (1 << DIVW) - 1;

  logic [CW-1:0] count;
  logic [CW-1:0] term;

  // Low div_lat bits set: 2^div_lat - 1 without needing a wider intermediate.
  assign term = ~({CW{1'b1}} << div_lat);
  // Decoded straight from the registered count so the scheduler can register
  // round_en at the same edge where the counter wraps.
  assign tick = en & (count == term);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (count == term) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_round_sched.sv
// aes_round_sched: sequences an iterative AES-128 round core using clock
// enables at a programmable slowed rate (one round every 2^div_sel cycles).
//   clk50      in   sole clock
//   reset      in   asynchronous active-high reset
//   start      in   request an operation (sampled in IDLE only)
//   abort      in   cancel operation (sampled in LOAD and RUN)
//   div_sel    in   round spacing select, latched on start acceptance
//   load       out  one-cycle pulse: core loads plaintext/key
//   round_en   out  one-cycle pulse: core performs one round
//   round_idx  out  current round number, valid with round_en
//   last_round out  high with round_en for the final round
//   busy       out  high in LOAD, RUN and DONE
//   done       out  one-cycle completion pulse
module aes_round_sched
  import aes_sched_pkg::*;
#(
  parameter int NROUNDS = NROUNDS_DEF,
  parameter int DIVW    = 3
) (
  input  logic            clk50,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [DIVW-1:0] div_sel,
  output logic            load,
  output logic            round_en,
  output logic [IDXW-1:0] round_idx,
  output logic            last_round,
  output logic            busy,
  output logic            done
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NROUNDS);

  state_t          state;
  logic [DIVW-1:0] div_lat;
  logic            tick;
  logic            tick_clear;
  logic            tick_en;

  // The divider already counts during LOAD: that cycle is count 0 of the
  // first round period, which puts round k at T0 + 1 + k*2^div_lat.
  assign tick_clear = (state == IDLE) | (state == DONE) | abort;
  assign tick_en    = (state == LOAD) | (state == RUN);

  tick_div #(.DIVW(DIVW)) u_tick_div (
    .clk50   (clk50),
    .reset   (reset),
    .clear   (tick_clear),
    .en      (tick_en),
    .div_lat (div_lat),
    .tick    (tick)
  );

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_lat    <= '0;
      load       <= 1'b0;
      round_en   <= 1'b0;
      round_idx  <= '0;
      last_round <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      load       <= 1'b0;
      round_en   <= 1'b0;
      last_round <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_lat   <= div_sel;
            round_idx <= '0;
            load      <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD, RUN: begin
          // abort wins over a coincident tick, so the pending round is lost.
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (state == RUN && last_round) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= RUN;
            if (tick) begin
              round_en   <= 1'b1;
              round_idx  <= round_idx + 1'b1;
              last_round <= (round_idx + 1'b1) == LAST_IDX;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sched.sv
module tb_aes_round_sched;

  localparam int N = 10;

  logic       clk50 = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] div_sel;
  logic       load;
  logic       round_en;
  logic [3:0] round_idx;
  logic       last_round;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  always #5 clk50 = ~clk50;

  aes_round_sched dut (
    .clk50      (clk50),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .div_sel    (div_sel),
    .load       (load),
    .round_en   (round_en),
    .round_idx  (round_idx),
    .last_round (last_round),
    .busy       (busy),
    .done       (done)
  );

  // Observed outputs packed as {load, round_en, round_idx, last_round, busy, done}.
  function automatic logic [8:0] obs();
    return {load, round_en, round_idx, last_round, busy, done};
  endfunction

  // Reference: expected outputs in cycle T0+t of an operation accepted at
  // edge T0 with ratio r; ac is the cycle offset in which abort is held
  // (ignored unless it falls in LOAD/RUN, i.e. 1..end-1).
  function automatic logic [8:0] model(int t, int r, int ac);
    int endt;
    int k;
    logic ld, re, lr, bz, dn;
    endt = 2 + N * r;
    if (ac >= 1 && ac < endt && t > ac) begin
      k = (ac - 1) / r;
      if (k > N) k = N;
      return {2'b00, 4'(k), 3'b000};
    end
    k = (t - 1) / r;
    if (k > N) k = N;
    ld = (t == 1);
    re = (t >= 2) && ((t - 1) % r == 0) && ((t - 1) / r <= N);
    lr = re && ((t - 1) / r == N);
    bz = (t >= 1) && (t <= endt);
    dn = (t == endt);
    return {ld, re, 4'(k), lr, bz, dn};
  endfunction

  task automatic launch(input logic [2:0] d);
    @(negedge clk50);
    start   = 1'b1;
    div_sel = d;
    @(posedge clk50);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b0; div_sel = 3'd5;
    repeat (3) @(posedge clk50);
    @(negedge clk50);
    total++;
    if (obs() !== 9'd0) $display("FAIL reset_state: got %b want %b", obs(), 9'd0);
    else passed++;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk50);
  endtask

  task automatic test_div0();
    logic [8:0] exp_v;
    launch(3'd0);
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk50);
      start = 1'b0;
      exp_v = model(t, 1, -1);
      total++;
      if (obs() !== exp_v) $display("FAIL div0 t=%0d: got %b want %b", t, obs(), exp_v);
      else passed++;
    end
  endtask

  task automatic test_div_rand();
    logic [2:0] divs [3];
    logic [8:0] exp_v;
    int r, endt, pulses;
    divs[0] = 3'd4;
    divs[1] = 3'($urandom_range(1, 3));
    divs[2] = 3'($urandom_range(0, 5));
    for (int i = 0; i < 3; i++) begin
      r = 1 << divs[i];
      endt = 2 + N * r;
      pulses = 0;
      launch(divs[i]);
      for (int t = 1; t <= endt + 2; t++) begin
        @(negedge clk50);
        start = 1'b0;
        if (round_en) pulses++;
        exp_v = model(t, r, -1);
        total++;
        if (obs() !== exp_v) $display("FAIL div%0d t=%0d: got %b want %b", divs[i], t, obs(), exp_v);
        else passed++;
      end
      total++;
      if (pulses !== N) $display("FAIL pulse_count div%0d: got %0d want %0d", divs[i], pulses, N);
      else passed++;
    end
  endtask

  task automatic test_ignore_busy_inputs();
    logic [8:0] exp_v;
    launch(3'd2);
    for (int t = 1; t <= 44; t++) begin
      @(negedge clk50);
      exp_v = model(t, 4, -1);
      total++;
      if (obs() !== exp_v) $display("FAIL ignore t=%0d: got %b want %b", t, obs(), exp_v);
      else passed++;
      // Random start pulses and div_sel changes only while busy (through DONE).
      start   = (t < 42) ? 1'($urandom_range(0, 1)) : 1'b0;
      div_sel = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic run_abort(input logic [2:0] d, input int ac, input string nm);
    logic [8:0] exp_v;
    int r;
    r = 1 << d;
    launch(d);
    for (int t = 1; t <= ac + 3; t++) begin
      @(negedge clk50);
      start = 1'b0;
      exp_v = model(t, r, ac);
      total++;
      if (obs() !== exp_v) $display("FAIL %s t=%0d: got %b want %b", nm, t, obs(), exp_v);
      else passed++;
      abort = (t == ac);
    end
    abort = 1'b0;
  endtask

  task automatic test_abort();
    int d;
    // Abort on the wrap that would produce round 5 at div 1.
    run_abort(3'd1, 10, "abort_wrap");
    // Abort in LOAD.
    run_abort(3'd0, 1, "abort_load");
    // Abort in the DONE cycle has no effect.
    run_abort(3'd0, 12, "abort_done");
    d = $urandom_range(0, 3);
    run_abort(3'(d), $urandom_range(1, 1 + N * (1 << d)), "abort_rand");
  endtask

  task automatic test_async_reset();
    logic [8:0] exp_v;
    launch(3'd2);
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk50);
      start = 1'b0;
      exp_v = model(t, 4, -1);
      total++;
      if (obs() !== exp_v) $display("FAIL pre_reset t=%0d: got %b want %b", t, obs(), exp_v);
      else passed++;
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs() !== 9'd0) $display("FAIL async_reset: got %b want %b", obs(), 9'd0);
    else passed++;
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    @(negedge clk50);
    test_div0();
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_v;
    launch(3'd0);
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk50);
      exp_v = model(((t - 1) % 13) + 1, 1, -1);
      total++;
      if (obs() !== exp_v) $display("FAIL b2b t=%0d: got %b want %b", t, obs(), exp_v);
      else passed++;
    end
    start = 1'b0;
    repeat (16) @(negedge clk50);
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL b2b_idle: got busy/done %b want 00", {busy, done});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_div0();
    test_div_rand();
    test_ignore_busy_inputs();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
